// File: rtl/button_debounce_array.sv
// Multi-channel pushbutton front end: 2-FF synchroniser, symmetric debounce, press/release
// pulses and per-channel typematic auto-repeat. Channels are fully independent; all outputs
// are registered in the clk domain except any_level, which is a plain OR of level.
module button_debounce_array #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter int unsigned REPEAT_DELAY    = 20000000,
  parameter int unsigned REPEAT_PERIOD   = 4000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] rpt_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] rpt,
  output logic             any_level
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RpSpan = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RpW    = $clog2(RpSpan);

  // Terminal counts, pre-cast to the counter widths.
  localparam logic [DbW-1:0] DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RpW-1:0] DlyLast = RpW'(REPEAT_DELAY - 1);
  localparam logic [RpW-1:0] PerLast = RpW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rpt_st_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic           sync1_q;
    logic           s_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           rel_q, rel_d;
    logic           rpt_q, rpt_d;
    rpt_st_e        st_q, st_d;
    logic [RpW-1:0] rp_cnt_q, rp_cnt_d;
    logic           rise, fall;

    // Debounce: accept a level change only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      if (s_q == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DbLast) begin
        level_d  = s_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    assign rise    = level_d & ~level_q;
    assign fall    = ~level_d & level_q;
    assign press_d = rise;
    assign rel_d   = fall;

    // Repeat FSM: a press with repeat enabled arms the delay, then the periodic phase.
    // A falling level or a dropped enable exits without a pulse, so rel always beats rpt.
    always_comb begin
      st_d     = st_q;
      rp_cnt_d = rp_cnt_q;
      rpt_d    = 1'b0;
      unique case (st_q)
        StIdle: begin
          rp_cnt_d = '0;
          if (rise && rpt_en[i]) begin
            st_d = StDelay;
          end
        end
        StDelay: begin
          if (fall || !rpt_en[i]) begin
            st_d     = StIdle;
            rp_cnt_d = '0;
          end else if (rp_cnt_q == DlyLast) begin
            st_d     = StRepeat;
            rp_cnt_d = '0;
            rpt_d    = 1'b1;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (fall || !rpt_en[i]) begin
            st_d     = StIdle;
            rp_cnt_d = '0;
          end else if (rp_cnt_q == PerLast) begin
            rp_cnt_d = '0;
            rpt_d    = 1'b1;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        default: begin
          st_d     = StIdle;
          rp_cnt_d = '0;
        end
      endcase
    end

    // Channel state: synchroniser, debounce, pulse outputs and repeat FSM.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q  <= 1'b0;
        s_q      <= 1'b0;
        db_cnt_q <= '0;
        level_q  <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        rpt_q    <= 1'b0;
        st_q     <= StIdle;
        rp_cnt_q <= '0;
      end else begin
        sync1_q  <= btn_in[i];
        s_q      <= sync1_q;
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
        rpt_q    <= rpt_d;
        st_q     <= st_d;
        rp_cnt_q <= rp_cnt_d;
      end
    end

    assign level[i] = level_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
    assign rpt[i]   = rpt_q;
  end

  assign any_level = |level;

endmodule
